// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU constants for the instruction-fetch front end:
// reset vector, bubble encoding and the fetch FSM state encoding.
package if_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  // Redirect targets are word aligned; low address bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps at most one imem request
// outstanding and hands complete instructions or flush bubbles to IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_wr_en,
  output logic        if_flush,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_next
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  hold_instr, hold_nxt;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;

  assign pc_plus4        = pc + PC_STEP;
  assign redirect_target = word_align(redirect_pc);
  assign imem_addr       = pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_instr <= hold_nxt;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case statement can infer a latch.
    state_nxt  = state;
    pc_nxt     = pc;
    hold_nxt   = hold_instr;
    imem_req   = 1'b0;
    if_wr_en   = 1'b0;
    if_flush   = 1'b0;
    if_instr   = NOP_INSTR;
    if_pc_next = '0;

    unique case (state)
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_nxt = redirect_target;
          // A grant on the old PC leaves a response that must be swallowed.
          if (imem_gnt) state_nxt = S_DROP;
        end else if (imem_gnt) begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_target;
          state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (!stall_in) begin
            if_wr_en   = 1'b1;
            if_instr   = imem_rdata;
            if_pc_next = pc_plus4;
            pc_nxt     = pc_plus4;
            state_nxt  = S_REQ;
          end else begin
            hold_nxt  = imem_rdata;
            state_nxt = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if_instr   = hold_instr;
        if_pc_next = pc_plus4;
        if (redirect_valid) begin
          pc_nxt    = redirect_target;
          state_nxt = S_REQ;
        end else if (!stall_in) begin
          if_wr_en  = 1'b1;
          pc_nxt    = pc_plus4;
          state_nxt = S_REQ;
        end
      end

      S_DROP: begin
        if (redirect_valid) pc_nxt = redirect_target;
        if (imem_rvalid)    state_nxt = S_REQ;
      end

      default: state_nxt = S_REQ;
    endcase

    // A redirect always writes a bubble, even over a hazard stall.
    if (redirect_valid) begin
      if_wr_en = 1'b1;
      if_flush = 1'b1;
      if_instr = NOP_INSTR;
    end

    // Outputs are quiet for as long as reset is held, not just at the edge.
    if (!reset) begin
      imem_req   = 1'b0;
      if_wr_en   = 1'b0;
      if_flush   = 1'b0;
      if_instr   = NOP_INSTR;
      if_pc_next = '0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes expected IF/ID writes to a
// scoreboard that a negedge monitor pops as the DUT raises if_wr_en.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  typedef struct {
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc_next;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_wr_en;
  logic        if_flush;
  logic [31:0] if_instr;
  logic [31:0] if_pc_next;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  wr_exp_t     sb[$];
  wr_exp_t     e;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_wr_en       (if_wr_en),
    .if_flush       (if_flush),
    .if_instr       (if_instr),
    .if_pc_next     (if_pc_next)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic flush, input logic [31:0] instr, input logic [31:0] pc_next);
    wr_exp_t x;
    x.flush   = flush;
    x.instr   = instr;
    x.pc_next = pc_next;
    sb.push_back(x);
  endtask

  // One clock cycle: check the request side at negedge, then move past posedge.
  task automatic expect_req(input logic req, input logic [31:0] addr);
    @(negedge clk);
    check("imem_req", {31'd0, imem_req}, {31'd0, req});
    if (req) check("imem_addr", imem_addr, addr);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (if_flush && !if_wr_en) check("flush_without_wr", 32'd1, 32'd0);
      if (if_wr_en) begin
        if (sb.size() == 0) begin
          check("unexpected_wr", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("if_flush", {31'd0, if_flush}, {31'd0, e.flush});
          check("if_instr", if_instr, e.instr);
          if (!e.flush) check("if_pc_next", if_pc_next, e.pc_next);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_req",     {31'd0, imem_req}, 32'd0);
    check("rst_wr_en",   {31'd0, if_wr_en}, 32'd0);
    check("rst_flush",   {31'd0, if_flush}, 32'd0);
    check("rst_instr",   if_instr, 32'd0);
    check("rst_pc_next", if_pc_next, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Best-case fetch
    imem_gnt = 1'b1;
    expect_req(1'b1, RST_PC);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2408_0001;
    push(1'b0, 32'h2408_0001, 32'h0040_0004);
    expect_req(1'b0, '0);
    imem_rvalid = 1'b0;

    // Stall over the rvalid cycle
    imem_gnt = 1'b1;
    expect_req(1'b1, 32'h0040_0004);
    imem_gnt = 1'b0; stall_in = 1'b1;
    expect_req(1'b0, '0);
    imem_rvalid = 1'b1; imem_rdata = 32'h8C09_0000;
    expect_req(1'b0, '0);
    imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    expect_req(1'b0, '0);
    stall_in = 1'b0;
    push(1'b0, 32'h8C09_0000, 32'h0040_0008);
    expect_req(1'b0, '0);

    // Redirect in S_WAIT, orphan response two cycles later
    imem_gnt = 1'b1;
    expect_req(1'b1, 32'h0040_0008);
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    push(1'b1, 32'h0, 32'h0);
    expect_req(1'b0, '0);
    redirect_valid = 1'b0;
    expect_req(1'b0, '0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    expect_req(1'b0, '0);
    imem_rvalid = 1'b0;
    expect_req(1'b1, 32'h0040_0100);
    imem_gnt = 1'b1;
    expect_req(1'b1, 32'h0040_0100);

    // Redirect coincident with rvalid and stall
    imem_gnt = 1'b0; imem_rvalid = 1'b1; stall_in = 1'b1; imem_rdata = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
    push(1'b1, 32'h0, 32'h0);
    expect_req(1'b0, '0);
    imem_rvalid = 1'b0; stall_in = 1'b0;
    redirect_pc = 32'hFFFF_FFFC;
    push(1'b1, 32'h0, 32'h0);
    expect_req(1'b1, 32'h0040_0200);
    redirect_valid = 1'b0;

    // PC wrap at the top of the address space
    imem_gnt = 1'b1;
    expect_req(1'b1, 32'hFFFF_FFFC);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    push(1'b0, 32'h0000_0013, 32'h0000_0000);
    expect_req(1'b0, '0);
    imem_rvalid = 1'b0;
    expect_req(1'b1, 32'h0000_0000);

    // Redirect with a grant in S_REQ drops the granted response
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0300;
    push(1'b1, 32'h0, 32'h0);
    expect_req(1'b1, 32'h0000_0000);
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    expect_req(1'b0, '0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    expect_req(1'b0, '0);
    imem_rvalid = 1'b0;

    // Reset asserted while holding a stalled instruction
    imem_gnt = 1'b1;
    expect_req(1'b1, 32'h0040_0300);
    imem_gnt = 1'b0; stall_in = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    expect_req(1'b0, '0);
    imem_rvalid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("hold_rst_req",     {31'd0, imem_req}, 32'd0);
    check("hold_rst_wr_en",   {31'd0, if_wr_en}, 32'd0);
    check("hold_rst_flush",   {31'd0, if_flush}, 32'd0);
    check("hold_rst_instr",   if_instr, 32'd0);
    check("hold_rst_pc_next", if_pc_next, 32'd0);
    stall_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    expect_req(1'b1, RST_PC);
    imem_gnt = 1'b1;
    expect_req(1'b1, RST_PC);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    push(1'b0, 32'h3333_3333, 32'h0040_0004);
    expect_req(1'b0, '0);
    imem_rvalid = 1'b0;
    expect_req(1'b1, 32'h0040_0004);

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
